// File: rtl/tnn_pkg.sv
// Shared types and helpers for the serial ternary-weight classifier.
// Ternary weight encoding: 01 = +1, 11 = -1, 00/10 = 0.
package tnn_pkg;

    localparam logic [1:0] TW_ZERO = 2'b00;
    localparam logic [1:0] TW_POS  = 2'b01;
    localparam logic [1:0] TW_NEG  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} tnn_state_e;

    function automatic logic signed [1:0] decode_tw(input logic [1:0] tw);
        case (tw)
            TW_POS:  return 2'sb01;
            TW_NEG:  return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic int unsigned hacc_width(input int unsigned in_w, input int unsigned n_in);
        return in_w + $clog2(n_in) + 2;
    endfunction

    function automatic int unsigned oacc_width(input int unsigned n_hid);
        return $clog2(n_hid) + 2;
    endfunction

    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tnn_tern_acc.sv
// Signed accumulator stepped by a ternary weight times an unsigned magnitude.
// sum_o is the running total including this cycle's term; clr_i zeroes the register after it.
module tnn_tern_acc
    import tnn_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic [1:0]          tw_i,
    input  logic [W-1:0]        mag_i,
    output logic signed [W-1:0] sum_o
);

    logic signed [W-1:0] acc_q, acc_d, term;

    always_comb begin
        term = '0;
        case (decode_tw(tw_i))
            2'sb01:  term = $signed(mag_i);
            2'sb11:  term = -$signed(mag_i);
            default: term = '0;
        endcase
        sum_o = acc_q + term;
        acc_d = clr_i ? '0 : sum_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/tnn_serial_classifier.sv
// Two-layer ternary-weight classifier evaluated one input term per cycle on a shared
// accumulator; hidden bits feed a second accumulator for the output neuron.
module tnn_serial_classifier
    import tnn_pkg::*;
#(
    parameter int unsigned               N_IN    = 5,
    parameter int unsigned               IN_W    = 2,
    parameter int unsigned               N_HID   = 3,
    parameter int unsigned               THR_W   = 8,
    parameter logic [N_HID*N_IN*2-1:0]   W_HID   = '0,
    parameter logic [N_HID*THR_W-1:0]    THR_HID = '0,
    parameter logic [N_HID*2-1:0]        W_OUT   = '0,
    parameter logic [THR_W-1:0]          THR_OUT = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_class,
    output logic                 busy
);

    localparam int unsigned HW  = hacc_width(IN_W, N_IN);
    localparam int unsigned OW  = oacc_width(N_HID);
    localparam int unsigned HCW = max_width(THR_W, HW);
    localparam int unsigned OCW = max_width(THR_W, OW);
    localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned HIW = (N_HID > 1) ? $clog2(N_HID) : 1;

    tnn_state_e            state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [HIW-1:0]        h_q, h_d;
    logic [N_IN*IN_W-1:0]  x_q, x_d;
    logic                  cls_q, cls_d;
    logic                  vld_q, vld_d;

    logic                  h_clr, o_clr;
    logic [1:0]            h_tw, o_tw;
    logic [HW-1:0]         h_mag;
    logic [OW-1:0]         o_mag;
    logic signed [HW-1:0]  h_sum;
    logic signed [OW-1:0]  o_sum;
    logic signed [THR_W-1:0] thr_h, thr_o;
    logic                  last_i, last_h, hbit, ocls;

    assign last_i = (i_q == IW'(N_IN - 1));
    assign last_h = (h_q == HIW'(N_HID - 1));
    assign h_mag  = HW'(x_q[int'(i_q)*IN_W +: IN_W]);
    assign thr_h  = THR_HID[int'(h_q)*THR_W +: THR_W];
    assign thr_o  = THR_OUT;
    // Compares are done at the wider of threshold and accumulator, both sign-extended.
    assign hbit   = HCW'(h_sum) >= HCW'(thr_h);
    assign ocls   = OCW'(o_sum) >= OCW'(thr_o);
    assign o_mag  = OW'(hbit);

    tnn_tern_acc #(.W(HW)) u_hacc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (h_clr),
        .tw_i  (h_tw),
        .mag_i (h_mag),
        .sum_o (h_sum)
    );

    tnn_tern_acc #(.W(OW)) u_oacc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (o_clr),
        .tw_i  (o_tw),
        .mag_i (o_mag),
        .sum_o (o_sum)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        h_d     = h_q;
        x_d     = x_q;
        cls_d   = cls_q;
        vld_d   = vld_q;
        h_clr   = 1'b0;
        o_clr   = 1'b0;
        h_tw    = TW_ZERO;
        o_tw    = TW_ZERO;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = in_data;
                    h_clr   = 1'b1;
                    o_clr   = 1'b1;
                    i_d     = '0;
                    h_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                h_tw = W_HID[(int'(h_q)*N_IN + int'(i_q))*2 +: 2];
                if (last_i) begin
                    h_clr = 1'b1;
                    o_tw  = W_OUT[int'(h_q)*2 +: 2];
                    i_d   = '0;
                    if (last_h) begin
                        h_d     = '0;
                        cls_d   = ocls;
                        state_d = StDone;
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StDone: begin
                // out_valid rises one edge after entering DONE and drops on the handshake edge.
                vld_d = 1'b1;
                if (vld_q && out_ready) begin
                    vld_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            cls_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            h_q     <= h_d;
            x_q     <= x_d;
            cls_q   <= cls_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = vld_q;
    assign out_class = cls_q;

endmodule

// File: tb/tb_tnn_serial_classifier.sv
// Directed bench: three classifier instances share stimulus, each with its own weight set.
module tb_tnn_serial_classifier;

    localparam logic [29:0] W_ALL_POS = {15{2'b01}};
    localparam logic [23:0] THR_A     = {8'd12, 8'd8, 8'd4};
    // Neuron 0 weights {+1,-1,0,+1,-1}; neurons 1 and 2 all zero.
    localparam logic [29:0] W_HID_B   = {20'd0, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01};
    localparam logic [23:0] THR_B     = {8'd1, 8'd1, 8'd0};

    localparam logic [9:0] V_ALL3 = {5{2'd3}};
    localparam logic [9:0] V_ALL0 = 10'd0;
    localparam logic [9:0] V_MIX1 = {2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
    localparam logic [9:0] V_MIX0 = {2'd0, 2'd0, 2'd2, 2'd3, 2'd3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [9:0] in_data = '0;

    logic rdy_a, vld_a, cls_a, busy_a;
    logic rdy_b, vld_b, cls_b, busy_b;
    logic rdy_c, vld_c, cls_c, busy_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tnn_serial_classifier #(
        .W_HID(W_ALL_POS), .THR_HID(THR_A), .W_OUT({3{2'b01}}), .THR_OUT(8'd2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .out_valid(vld_a), .out_ready(out_ready), .out_class(cls_a), .busy(busy_a)
    );

    tnn_serial_classifier #(
        .W_HID(W_HID_B), .THR_HID(THR_B), .W_OUT({2'b00, 2'b00, 2'b01}), .THR_OUT(8'd1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .out_valid(vld_b), .out_ready(out_ready), .out_class(cls_b), .busy(busy_b)
    );

    tnn_serial_classifier #(
        .W_HID(W_ALL_POS), .THR_HID(THR_A), .W_OUT({3{2'b11}}), .THR_OUT(8'hFF)
    ) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
        .out_valid(vld_c), .out_ready(out_ready), .out_class(cls_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [9:0] data, input logic ea,
                           input logic eb, input logic ec, input int hold, input bit poke);
        int lat;
        in_data  = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "/busy"}, 32'(busy_a), 1);
        check({tag, "/rdy_run"}, 32'(rdy_a), 0);
        lat = 0;
        while (!vld_a && lat < 40) begin
            if (poke) begin
                in_valid = (lat >= 2 && lat <= 8);
                in_data  = (lat >= 2 && lat <= 8) ? ~data : data;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        in_data  = data;
        check({tag, "/latency"}, 32'(lat), 16);
        check({tag, "/vld_c"}, 32'(vld_c), 1);
        check({tag, "/cls_a"}, 32'(cls_a), 32'(ea));
        check({tag, "/cls_b"}, 32'(cls_b), 32'(eb));
        check({tag, "/cls_c"}, 32'(cls_c), 32'(ec));
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "/hold_vld"}, 32'(vld_a), 1);
            check({tag, "/hold_cls"}, 32'(cls_a), 32'(ea));
            check({tag, "/hold_rdy"}, 32'(rdy_a), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/vld_drop_a"}, 32'(vld_a), 0);
        check({tag, "/vld_drop_b"}, 32'(vld_b), 0);
        check({tag, "/rdy_back"}, 32'(rdy_a), 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst/rdy", 32'(rdy_a), 1);
        check("rst/vld", 32'(vld_a), 0);
        check("rst/cls", 32'(cls_a), 0);
        check("rst/busy", 32'(busy_a), 0);
        rst = 1'b0;
        tick();

        run_vec("all3", V_ALL3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_vec("all0", V_ALL0, 1'b0, 1'b1, 1'b1, 10, 1'b0);
        run_vec("mix1", V_MIX1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        run_vec("mix0", V_MIX0, 1'b1, 1'b1, 1'b0, 2, 1'b0);

        // Abort in the middle of RUN; previous classes were 1 so the clear is visible.
        in_data  = V_ALL3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort/rdy", 32'(rdy_a), 1);
        check("abort/vld", 32'(vld_a), 0);
        check("abort/busy", 32'(busy_a), 0);
        check("abort/cls_a", 32'(cls_a), 0);
        check("abort/cls_b", 32'(cls_b), 0);
        run_vec("post_rst", V_ALL0, 1'b0, 1'b1, 1'b1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
